// File: rtl/plot_pkg.sv
// rtl/plot_pkg.sv - shared screen geometry, pixel type and address helpers for the plot sink
package plot_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ADDR_W   = 15;
  localparam int COLOR_W  = 3;

  typedef struct packed {
    logic [7:0]         x;
    logic [6:0]         y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  // Linear framebuffer address y*160 + x built from shifts; wraps at 15 bits.
  function automatic logic [ADDR_W-1:0] pixel_addr(input pixel_t p);
    logic [ADDR_W-1:0] w_y;
    logic [ADDR_W-1:0] w_x;
    w_y = {{(ADDR_W-7){1'b0}}, p.y};
    w_x = {{(ADDR_W-8){1'b0}}, p.x};
    return (w_y << 7) + (w_y << 5) + w_x;
  endfunction

  // True when the pixel lies on the visible 160x120 screen.
  function automatic logic pixel_in_range(input pixel_t p);
    return (p.x < 8'(SCREEN_W)) && (p.y < 7'(SCREEN_H));
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// rtl/plot_fifo.sv - DEPTH-entry synchronous FIFO of pixel_t with occupancy count
module plot_fifo
  import plot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  pixel_t                     i_data,
  input  logic                       i_pop,
  output pixel_t                     o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pixel_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Storage write and write pointer; pointer wraps naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
    end else if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
      r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
    end
  end

  // Read pointer advances on every pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_ptr <= '0;
    else if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/pixel_plot_sink.sv
// rtl/pixel_plot_sink.sv - buffers plot requests and issues framebuffer writes; PLOT_CLIP_EN enables off-screen discard
module pixel_plot_sink
  import plot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               plotIn,
  input  logic [7:0]         xIn,
  input  logic [6:0]         yIn,
  input  logic [COLOR_W-1:0] colorIn,
  output logic               readyOut,
  output logic               memWrEn,
  output logic [ADDR_W-1:0]  memAddr,
  output logic [COLOR_W-1:0] memData,
  input  logic               memReady,
  output logic               idleOut,
  output logic [7:0]         clipCount
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  pixel_t              w_in_pix;
  pixel_t              w_out_pix;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_commit;
  logic                w_keep;
  logic [CNT_W-1:0]    w_count;

  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [COLOR_W-1:0]  r_data;

  assign w_in_pix = '{x: xIn, y: yIn, color: colorIn};

  // readyOut comes only from the FIFO count, never from memReady.
  assign readyOut = !w_full;
  assign w_push   = plotIn && readyOut;
  assign w_commit = r_wr_en && memReady;
  assign w_pop    = !w_empty && (!r_wr_en || memReady);

  plot_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_data (w_in_pix),
    .i_pop  (w_pop),
    .o_data (w_out_pix),
    .o_count(w_count),
    .o_full (w_full),
    .o_empty(w_empty)
  );

`ifdef PLOT_CLIP_EN
  logic [7:0] r_clip_count;

  assign w_keep = pixel_in_range(w_out_pix);

  // Count discarded off-screen pixels, saturating at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_clip_count <= '0;
    else if (w_pop && !w_keep && (r_clip_count != 8'hFF)) r_clip_count <= r_clip_count + 8'd1;
  end

  assign clipCount = r_clip_count;
`else
  assign w_keep    = 1'b1;
  assign clipCount = '0;
`endif

  // Output stage: load on a kept pop, hold while stalled, clear when a commit has nothing behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (w_pop && w_keep) begin
      r_wr_en <= 1'b1;
      r_addr  <= pixel_addr(w_out_pix);
      r_data  <= w_out_pix.color;
    end else if (w_commit) begin
      r_wr_en <= 1'b0;
    end
  end

  assign memWrEn = r_wr_en;
  assign memAddr = r_addr;
  assign memData = r_data;
  assign idleOut = (w_count == '0) && !r_wr_en;

endmodule
